branch_resolve: RTL

Resolves conditional branches in the execute stage of the single-core integration. It consumes the `eq`/`lt`/`ltu` flags from the `n`-bit comparator plus the branch funct3, and decides taken/not-taken against the fetch prediction. On a mispredict it issues a flush and holds a redirect to fetch under a valid/ready handshake. It also keeps saturating branch and mispredict counters for the performance monitor.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_cond.sv | 28 ++
 rtl/branch_resolve.sv | 115 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the execute-stage branch resolver.
package branch_pkg;

    // Branch funct3 encodings; 010 and 011 are reserved and decode as illegal.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Resolver FSM: IDLE accepts branches, REDIRECT holds a corrected PC for fetch.
    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition decode: funct3 plus comparator flags to taken/illegal.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    // Select the flag for this branch type; reserved encodings are never taken.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: decides taken, detects mispredicts, holds a
// redirect for fetch and keeps saturating branch/mispredict counters.
//
// Handshakes: a branch transfers on a cycle where ex_valid && ex_ready; the
// redirect transfers on a cycle where redirect_valid && redirect_ready. Once
// redirect_valid is raised it and redirect_pc stay put until that transfer.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int n  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [2:0]    funct3,
    input  logic          eq,
    input  logic          lt,
    input  logic          ltu,
    input  logic [n-1:0]  pc,
    input  logic [n-1:0]  imm,
    input  logic          pred_taken,
    output logic          flush,
    output logic          redirect_valid,
    output logic [n-1:0]  redirect_pc,
    input  logic          redirect_ready,
    output logic          illegal,
    output logic [CW-1:0] br_count,
    output logic [CW-1:0] mp_count,
    output br_state_t     dbg_state
);

    br_state_t     r_state;
    br_state_t     w_next_state;
    logic          w_taken;
    logic          w_illegal;
    logic          w_xfer;
    logic          w_legal_xfer;
    logic          w_mispredict;
    logic [n-1:0]  w_target;
    logic [n-1:0]  w_fall;
    logic          r_flush;
    logic          r_illegal;
    logic [n-1:0]  r_redirect_pc;
    logic [CW-1:0] r_br_count;
    logic [CW-1:0] r_mp_count;

    branch_cond u_cond (
        .funct3  (funct3),
        .eq      (eq),
        .lt      (lt),
        .ltu     (ltu),
        .taken   (w_taken),
        .illegal (w_illegal)
    );

    // Flags are only meaningful on a transfer; in REDIRECT nothing is accepted.
    assign w_xfer       = ex_valid && (r_state == IDLE);
    assign w_legal_xfer = w_xfer && !w_illegal;
    assign w_mispredict = w_legal_xfer && (w_taken != pred_taken);

    // Both addresses wrap modulo 2^n; the carry out is intentionally dropped.
    assign w_target = pc + imm;
    assign w_fall   = pc + n'(4);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_next_state   = r_state;
        ex_ready       = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            IDLE: begin
                ex_ready = 1'b1;
                if (w_mispredict) w_next_state = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Registered pulses, redirect address and saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush       <= 1'b0;
            r_illegal     <= 1'b0;
            r_redirect_pc <= '0;
            r_br_count    <= '0;
            r_mp_count    <= '0;
        end else begin
            r_flush   <= w_mispredict;
            r_illegal <= w_xfer && w_illegal;
            if (w_mispredict) r_redirect_pc <= w_taken ? w_target : w_fall;
            if (w_legal_xfer && (r_br_count != {CW{1'b1}})) r_br_count <= r_br_count + CW'(1);
            if (w_mispredict && (r_mp_count != {CW{1'b1}})) r_mp_count <= r_mp_count + CW'(1);
        end
    end

    assign flush       = r_flush;
    assign illegal     = r_illegal;
    assign redirect_pc = r_redirect_pc;
    assign br_count    = r_br_count;
    assign mp_count    = r_mp_count;
    assign dbg_state   = r_state;

endmodule
